// File: rtl/layer1_output_collector.sv
// ----------------------------------------------------------------------------
// layer1_output_collector
//
// Buffers one complete Layer1 output frame from the four-channel pixel
// stream, then drains it channel-major (all of channel 0, then channel 1, and
// so on) as a single-word valid/ready stream. Only one frame is held at a
// time. Any input that arrives while the frame is being loaded or drained is
// dropped, and the sticky overflow flag records that it happened.
//
// Ports
//   clk        : single clock; every state change happens on its rising edge
//   rst        : asynchronous active-low reset
//   valid_in   : qualifies In_0..In_3 for one cycle
//   In_0..In_3 : channel 0..3 pixel words, in raster order
//   rd_ready   : downstream accepts data_out this cycle
//   out_valid  : data_out holds a valid word
//   data_out   : drained pixel word
//   out_ch     : channel of the current data_out word
//   out_idx    : pixel index of the current data_out word
//   frame_done : one-cycle pulse after the last pixel of a frame is captured
//   busy       : high while the block is loading or draining
//   overflow   : sticky; set when a valid_in is dropped, cleared only by reset
// ----------------------------------------------------------------------------
module layer1_output_collector #(
  parameter int Datawidth    = 16,
  parameter int FRAME_PIXELS = 9,
  parameter int ADDR_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [Datawidth-1:0] In_0,
  input  logic [Datawidth-1:0] In_1,
  input  logic [Datawidth-1:0] In_2,
  input  logic [Datawidth-1:0] In_3,
  input  logic                 rd_ready,
  output logic                 out_valid,
  output logic [Datawidth-1:0] data_out,
  output logic [1:0]           out_ch,
  output logic [ADDR_W-1:0]    out_idx,
  output logic                 frame_done,
  output logic                 busy,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [1:0]        LAST_CH  = 2'd3;

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      wr_cnt_q, wr_cnt_d;
  logic [1:0]             ch_q, ch_d;
  logic [ADDR_W-1:0]      idx_q, idx_d;
  logic [Datawidth-1:0]   data_q, data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overflow_q, overflow_d;

  // One bank per channel; bank_q[k] holds the pixels of channel k.
  logic [Datawidth-1:0]   bank_q [4][FRAME_PIXELS];

  logic                   bank_we;

  // Banks are written only while capturing. Input seen in LOAD/DRAIN never
  // reaches the storage, so the frame being drained cannot be corrupted.
  assign bank_we = (state_q == CAPTURE) && valid_in;

  // NOTE: the banks are plain storage with no reset. Their contents are
  // always overwritten by a full capture before they are read, so a reset
  // would only add a clear network across every word for no functional gain.
  always_ff @(posedge clk) begin
    if (bank_we) begin
      bank_q[0][wr_cnt_q] <= In_0;
      bank_q[1][wr_cnt_q] <= In_1;
      bank_q[2][wr_cnt_q] <= In_2;
      bank_q[3][wr_cnt_q] <= In_3;
    end
  end

  // NOTE: every variable assigned here receives a default first, so that no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    ch_d         = ch_q;
    idx_d        = idx_q;
    data_d       = data_q;
    out_valid_d  = out_valid_q;
    frame_done_d = 1'b0;
    // Any valid_in outside CAPTURE is a dropped pixel, including one that
    // coincides with the final transfer edge (state is still DRAIN there).
    overflow_d   = overflow_q | (valid_in && (state_q != CAPTURE));

    unique case (state_q)
      CAPTURE: begin
        if (valid_in) begin
          if (wr_cnt_q == LAST_IDX) begin
            wr_cnt_d     = '0;
            state_d      = LOAD;
            frame_done_d = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          end
        end
      end

      LOAD: begin
        ch_d        = '0;
        idx_d       = '0;
        data_d      = bank_q[0][0];
        out_valid_d = 1'b1;
        state_d     = DRAIN;
      end

      DRAIN: begin
        if (out_valid_q && rd_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (ch_q == LAST_CH) begin
              // Final word of the frame accepted; data_out keeps the last
              // word but out_valid drops, so it is no longer presented.
              ch_d        = '0;
              out_valid_d = 1'b0;
              state_d     = CAPTURE;
            end else begin
              ch_d = ch_q + 2'd1;
            end
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
          // Load the next word on the same edge as the transfer, which keeps
          // the stream bubble-free while rd_ready stays high.
          if (state_d == DRAIN) begin
            data_d = bank_q[ch_d][idx_d];
          end
        end
      end

      default: begin
        state_d = CAPTURE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its _d value from before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= CAPTURE;
      wr_cnt_q     <= '0;
      ch_q         <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      ch_q         <= ch_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign data_out   = data_q;
  assign out_ch     = ch_q;
  assign out_idx    = idx_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q != CAPTURE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_layer1_output_collector.sv
// ----------------------------------------------------------------------------
// tb_layer1_output_collector
//
// Directed bench for layer1_output_collector. Each captured frame pushes its
// 36 expected words (channel-major) onto a scoreboard queue; every transfer
// the DUT makes pops one entry and compares data, channel and index.
// ----------------------------------------------------------------------------
module tb_layer1_output_collector;

  localparam int DW    = 16;
  localparam int FP    = 9;
  localparam int AW    = 4;
  localparam int WORDS = 4 * FP;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] in0 = '0;
  logic [DW-1:0] in1 = '0;
  logic [DW-1:0] in2 = '0;
  logic [DW-1:0] in3 = '0;
  logic          rd_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] data_out;
  logic [1:0]    out_ch;
  logic [AW-1:0] out_idx;
  logic          frame_done;
  logic          busy;
  logic          overflow;

  layer1_output_collector #(
    .Datawidth    (DW),
    .FRAME_PIXELS (FP),
    .ADDR_W       (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .In_0       (in0),
    .In_1       (in1),
    .In_2       (in2),
    .In_3       (in3),
    .rd_ready   (rd_ready),
    .out_valid  (out_valid),
    .data_out   (data_out),
    .out_ch     (out_ch),
    .out_idx    (out_idx),
    .frame_done (frame_done),
    .busy       (busy),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    ch;
    logic [AW-1:0] idx;
  } exp_t;

  exp_t          exp_q[$];
  int            checks     = 0;
  int            failures   = 0;
  int            xfers      = 0;
  int            frame_base = 0;
  int            fd_count   = 0;
  logic          xfer_now   = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  logic [1:0]    prev_ch    = '0;
  logic [AW-1:0] prev_idx   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input logic [DW-1:0] base, input int k, input int i);
    return base | DW'(k << 8) | DW'(i);
  endfunction

  // One cycle: observe outputs on the falling edge, score any transfer that
  // the coming rising edge will perform, then present rd_ready for it.
  task automatic tick(input logic rdy);
    exp_t e;
    @(negedge clk);
    if (out_valid && prev_stall)
      check("stall_hold", {10'd0, data_out, out_ch, out_idx},
            {10'd0, prev_data, prev_ch, prev_idx});
    if (frame_done) fd_count++;
    xfer_now = out_valid && rdy;
    if (xfer_now) begin
      if (exp_q.size() == 0) begin
        check("extra_word", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("word_data", 32'(data_out), 32'(e.data));
        check("word_ch",   32'(out_ch),   32'(e.ch));
        check("word_idx",  32'(out_idx),  32'(e.idx));
      end
      xfers++;
    end
    prev_stall = out_valid && !rdy;
    prev_data  = data_out;
    prev_ch    = out_ch;
    prev_idx   = out_idx;
    rd_ready   = rdy;
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_data_out",   32'(data_out),   32'd0);
    check("rst_out_ch",     32'(out_ch),     32'd0);
    check("rst_out_idx",    32'(out_idx),    32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_overflow",   32'(overflow),   32'd0);
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one frame (In_k = base | k<<8 | i), optionally with an idle cycle
  // between pixels, then check the frame_done cycle and queue the drain.
  task automatic capture_frame(input logic [DW-1:0] base, input bit gap);
    for (int i = 0; i < FP; i++) begin
      tick(1'b1);
      valid_in = 1'b1;
      in0 = pix(base, 0, i);
      in1 = pix(base, 1, i);
      in2 = pix(base, 2, i);
      in3 = pix(base, 3, i);
      if (gap && i < FP - 1) begin
        tick(1'b1);
        valid_in = 1'b0;
      end
    end
    tick(1'b1);
    valid_in = 1'b0;
    check("frame_done_pulse", 32'(frame_done), 32'd1);
    check("busy_in_load",     32'(busy),       32'd1);
    check("no_word_in_load",  32'(out_valid),  32'd0);
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < FP; i++)
        exp_q.push_back('{data: pix(base, k, i), ch: 2'(k), idx: AW'(i)});
    frame_base = xfers;
  endtask

  // Run until `target` words of the current frame have transferred.
  // bp: rd_ready follows 1,0,0,1. vmode 1: valid_in (In_0=DEAD) every cycle;
  // vmode 2: valid_in only on the final-transfer edge.
  task automatic drain(input int target, input bit bp, input int vmode);
    int   c;
    logic r;
    c = 0;
    while ((xfers - frame_base) < target && c < 400) begin
      r = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      tick(r);
      c++;
      valid_in = (vmode == 1) ||
                 (vmode == 2 && xfer_now && (xfers - frame_base) == WORDS);
      in0 = 16'hDEAD;
    end
    check("drain_count", 32'(xfers - frame_base), 32'(target));
  endtask

  // Called right after a full drain: look just past the final transfer edge.
  task automatic check_idle_after_frame();
    @(posedge clk);
    #1;
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_busy",      32'(busy),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Basic frame, with first-word latency checked explicitly.
    capture_frame(16'h0000, 1'b0);
    tick(1'b1);
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_ch",    32'(out_ch),    32'd0);
    check("first_idx",   32'(out_idx),   32'd0);
    check("first_data",  32'(data_out),  32'h0000);
    drain(WORDS, 1'b0, 0);
    check_idle_after_frame();

    // Back-to-back: pixel 0 driven in the cycle right after the last transfer.
    capture_frame(16'h0400, 1'b0);
    drain(WORDS, 1'b0, 0);
    check_idle_after_frame();
    check("no_overflow_b2b", 32'(overflow), 32'd0);

    // Gapped input plus 1,0,0,1 backpressure.
    capture_frame(16'h0000, 1'b1);
    drain(WORDS, 1'b1, 0);
    check_idle_after_frame();

    // Input during LOAD/DRAIN is dropped and flagged.
    capture_frame(16'h0800, 1'b0);
    drain(WORDS, 1'b0, 1);
    check_idle_after_frame();
    check("overflow_set", 32'(overflow), 32'd1);
    capture_frame(16'h2000, 1'b0);
    drain(WORDS, 1'b1, 0);
    check_idle_after_frame();
    check("overflow_sticky", 32'(overflow), 32'd1);
    do_reset();

    // valid_in only on the final transfer edge.
    capture_frame(16'h3000, 1'b0);
    drain(WORDS, 1'b0, 2);
    check_idle_after_frame();
    check("overflow_last_edge", 32'(overflow), 32'd1);

    // Reset in the middle of a drain, then a fresh frame.
    capture_frame(16'h4000, 1'b0);
    drain(10, 1'b0, 0);
    valid_in = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    capture_frame(16'h1000, 1'b0);
    drain(WORDS, 1'b0, 0);
    check_idle_after_frame();

    check("queue_empty",      32'(exp_q.size()), 32'd0);
    check("frame_done_count", 32'(fd_count),     32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
